fir_coeff_sequencer: RTL
========================

# fir_coeff_sequencer

Run-time coefficient loader and flush sequencer for a chain of 4-tap systolic preadd filter blocks. Coefficient words are written over a valid/ready port into a shadow bank. A commit then copies the whole bank atomically into the active coefficient bus, pulses the filter reset, and holds the output qualifier low until the systolic pipeline has refilled. It sits between the register/control fabric and the coefficient and reset inputs of the filter chain.

## Interface
- NCHAIN, 2: number of 4-tap filter blocks driven; NTAPS = 4*NCHAIN.
- FLUSH_CYCLES, 12: cycles `valid_o` stays low after the reset pulse; ≥1; equals filter pipeline latency.
- ADDR_BITS, 8: width of `wr_addr_i`; 2^ADDR_BITS ≥ NTAPS.
- clk_i  in  1  filter clock.
- rst_i  in  1  synchronous, active-high reset.
- wr_valid_i  in  1  coefficient write request.
- wr_ready_o  out  1  write accepted when `wr_valid_i && wr_ready_o` at a clock edge.
- wr_addr_i  in  ADDR_BITS  tap index, 0..NTAPS-1.
- wr_data_i  in  18  signed coefficient.
- commit_i  in  1  single-cycle request to activate the shadow bank.
- coeff_o  out  18*NTAPS  active coefficients; tap k at [18k +: 18]; tap 4j+i drives coeff{i}_i of filter block j.
- filt_rst_o  out  1  drives the filter `rst_i`.
- valid_o  out  1  filter output qualifier.
- busy_o  out  1  high in any state other than IDLE.
- err_o  out  1  sticky out-of-range write flag.

## Operation
- FSM states: IDLE, SWAP, FLUSH. Reset state is SWAP.
- **IDLE**
  - `wr_ready_o` = 1. An accepted write sets shadow[wr_addr_i] = wr_data_i.
  - Write with address ≥ NTAPS: accepted, discarded, `err_o` set. `err_o` is cleared only by `rst_i`.
  - `commit_i` moves the FSM to SWAP.
  - If a write and `commit_i` occur in the same cycle, the write lands and is included in the swap.
- **SWAP** (exactly 1 cycle)
  - `filt_rst_o` = 1 and `wr_ready_o` = 0.
  - The active bank is loaded from the shadow bank at the end of the cycle.
  - Next state is FLUSH and the counter is loaded with FLUSH_CYCLES.
- **FLUSH**
  - `wr_ready_o` = 0 and `valid_o` = 0. The counter decrements each cycle.
  - At count 1: go to SWAP if a commit is pending, otherwise go to IDLE.
- **Pending commit:** a `commit_i` seen during SWAP or FLUSH sets a one-deep pending flag. It is cleared on entry to SWAP. Extra commits merge into that single pending commit.
- **Reset values:** `coeff_o` = 0, shadow bank = 0, `filt_rst_o` = 1, `valid_o` = 0, `busy_o` = 1, `wr_ready_o` = 0, `err_o` = 0, pending = 0.
- `rst_i` asserted mid-sequence aborts the sequence immediately and applies the reset values.
- Coefficients are never modified, only stored. No arithmetic is performed.

## Timing
- All outputs are registered or decoded from the registered state.
- `commit_i` sampled at edge E (while in IDLE):
  - cycle after E: SWAP, `filt_rst_o` = 1.
  - `coeff_o` shows the new values from the following cycle.
  - FLUSH lasts FLUSH_CYCLES cycles.
  - `valid_o` and `wr_ready_o` return high at cycle E+2+FLUSH_CYCLES.
- After `rst_i` deasserts: SWAP (loads zeros), then FLUSH, then IDLE.
- `coeff_o` is stable whenever `valid_o` = 1. It only changes at the end of SWAP.

## Configuration
- Macro: FIR_COEFF_SEQ_READBACK_EN.
- **Defined:** adds ports `rd_addr_i` (in, ADDR_BITS) and `rd_data_o` (out, 18).
  - `rd_data_o` = shadow[rd_addr_i], registered, 1-cycle latency.
  - Returns 0 for out-of-range addresses and in the cycle after reset.
  - Readback is valid in all states.
- **Undefined:** readback ports are absent. Shadow bank is write-only.

## Structure
- Package fir_ctrl_pkg holds:
  - COEFF_BITS = 18;
  - the state enum (IDLE, SWAP, FLUSH);
  - a helper function for the coefficient slice index.
- One sub-module, fir_coeff_bank, containing:
  - the shadow and active register arrays;
  - the write port, swap strobe, flat active output and optional readback.
- The FSM, flush counter, pending flag and error flag stay in the top module.

## Test plan
- **Reset:** hold `rst_i` 3 cycles → `filt_rst_o` = 1, `busy_o` = 1, `coeff_o` = 0. After release, `filt_rst_o` is high for 1 cycle and `valid_o` rises exactly FLUSH_CYCLES+1 cycles later.
- **Load and commit:** write taps 0..7 = 1..8, then `commit_i` → `coeff_o` unchanged until the SWAP cycle ends, then tap k = k+1. `valid_o` = 0 for exactly FLUSH_CYCLES cycles after SWAP.
- **Write and commit in the same cycle:** write tap 3 = 18'h1FFFF together with `commit_i` → active tap 3 = 18'h1FFFF after the swap.
- **Backpressure and pending commit:** `commit_i` during FLUSH, writes held with `wr_valid_i` = 1 → `wr_ready_o` = 0 throughout. A second SWAP follows immediately after FLUSH. The held write is accepted only after returning to IDLE.
- **Bad address:** write to address 8 with NCHAIN = 2 → `err_o` = 1 and stays high through later commits. Shadow is unchanged; with readback enabled, addresses 0..7 read back unchanged.
- **Mid-flush reset:** assert `rst_i` in FLUSH cycle 5 → `coeff_o` = 0, pending is cleared, and the post-reset sequence matches the reset scenario.

Source files
------------

// File: rtl/fir_ctrl_pkg.sv
// Shared types and constants for the FIR coefficient sequencer: coefficient width,
// sequencer state encoding and the flat-bus slice helper.
package fir_ctrl_pkg;

    localparam int COEFF_BITS = 18;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWAP  = 2'd1,
        FLUSH = 2'd2
    } seq_state_e;

    function automatic int coeff_lsb(input int tap);
        return tap * COEFF_BITS;
    endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Shadow/active coefficient register bank with atomic shadow-to-active swap.
// Optional registered shadow readback when FIR_COEFF_SEQ_READBACK_EN is defined.
module fir_coeff_bank
    import fir_ctrl_pkg::*;
#(
    parameter int NTAPS     = 8,
    parameter int ADDR_BITS = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        we_i,
    input  logic [ADDR_BITS-1:0]        waddr_i,
    input  logic [COEFF_BITS-1:0]       wdata_i,
    input  logic                        swap_i,
`ifdef FIR_COEFF_SEQ_READBACK_EN
    input  logic [ADDR_BITS-1:0]        rd_addr_i,
    output logic [COEFF_BITS-1:0]       rd_data_o,
`endif
    output logic [COEFF_BITS*NTAPS-1:0] coeff_o
);

    logic signed [COEFF_BITS-1:0] shadow_q [NTAPS];
    logic signed [COEFF_BITS-1:0] active_q [NTAPS];

    // A write and a swap in the same cycle cannot happen: writes are only taken in IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < NTAPS; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NTAPS; k++) begin
                if (we_i && waddr_i == ADDR_BITS'(k)) shadow_q[k] <= wdata_i;
                if (swap_i) active_q[k] <= shadow_q[k];
            end
        end
    end

    for (genvar k = 0; k < NTAPS; k++) begin : g_flat
        assign coeff_o[coeff_lsb(k) +: COEFF_BITS] = active_q[k];
    end

`ifdef FIR_COEFF_SEQ_READBACK_EN
    logic signed [COEFF_BITS-1:0] rd_data_d, rd_data_q;

    always_comb begin
        rd_data_d = '0;
        for (int k = 0; k < NTAPS; k++) begin
            if (rd_addr_i == ADDR_BITS'(k)) rd_data_d = shadow_q[k];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) rd_data_q <= '0;
        else       rd_data_q <= rd_data_d;
    end

    assign rd_data_o = rd_data_q;
`endif

endmodule

// File: rtl/fir_coeff_sequencer.sv
// Coefficient loader and flush sequencer for a chain of 4-tap systolic FIR blocks.
// Define FIR_COEFF_SEQ_READBACK_EN to add the rd_addr_i/rd_data_o shadow readback port.
module fir_coeff_sequencer
    import fir_ctrl_pkg::*;
#(
    parameter int NCHAIN       = 2,
    parameter int FLUSH_CYCLES = 12,
    parameter int ADDR_BITS    = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             wr_valid_i,
    output logic                             wr_ready_o,
    input  logic [ADDR_BITS-1:0]             wr_addr_i,
    input  logic [COEFF_BITS-1:0]            wr_data_i,
    input  logic                             commit_i,
`ifdef FIR_COEFF_SEQ_READBACK_EN
    input  logic [ADDR_BITS-1:0]             rd_addr_i,
    output logic [COEFF_BITS-1:0]            rd_data_o,
`endif
    output logic [COEFF_BITS*4*NCHAIN-1:0]   coeff_o,
    output logic                             filt_rst_o,
    output logic                             valid_o,
    output logic                             busy_o,
    output logic                             err_o
);

    localparam int NTAPS = 4 * NCHAIN;
    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(FLUSH_CYCLES);
    localparam logic [ADDR_BITS:0]   NTAPS_A  = (ADDR_BITS + 1)'(NTAPS);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             err_q, err_d;
    logic             wr_fire, addr_ok;

    assign wr_fire = wr_valid_i && (state_q == IDLE);
    assign addr_ok = {1'b0, wr_addr_i} < NTAPS_A;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (wr_fire && !addr_ok) err_d = 1'b1;
                if (commit_i) state_d = SWAP;
            end
            SWAP: begin
                state_d = FLUSH;
                cnt_d   = CNT_LOAD;
                if (commit_i) pend_d = 1'b1;
            end
            FLUSH: begin
                if (commit_i) pend_d = 1'b1;
                // A commit arriving on the final flush cycle still chains straight into SWAP.
                if (cnt_q == CNT_W'(1)) state_d = (pend_q || commit_i) ? SWAP : IDLE;
                else                    cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = SWAP;
        endcase
        if (state_d == SWAP && state_q != SWAP) pend_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SWAP;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    assign wr_ready_o = (state_q == IDLE);
    assign valid_o    = (state_q == IDLE);
    assign busy_o     = (state_q != IDLE);
    assign filt_rst_o = (state_q == SWAP);
    assign err_o      = err_q;

    fir_coeff_bank #(
        .NTAPS     (NTAPS),
        .ADDR_BITS (ADDR_BITS)
    ) u_bank (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .we_i      (wr_fire && addr_ok),
        .waddr_i   (wr_addr_i),
        .wdata_i   (wr_data_i),
        .swap_i    (state_q == SWAP),
`ifdef FIR_COEFF_SEQ_READBACK_EN
        .rd_addr_i (rd_addr_i),
        .rd_data_o (rd_data_o),
`endif
        .coeff_o   (coeff_o)
    );

endmodule
